// File: rtl/draw_pkg.sv
// Shared types and constants for the per-frame draw scheduler.
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SNAKE_START,
    SNAKE_PRIME,
    SNAKE_DRAW,
    FOOD,
    FINISH
  } draw_state_e;

  localparam logic [1:0] COLOR_BG    = 2'b00;
  localparam logic [1:0] COLOR_SNAKE = 2'b01;
  localparam logic [1:0] COLOR_FOOD  = 2'b10;

  localparam int CELL = 10;

endpackage

// File: rtl/raster_counter.sv
// Two-dimensional raster counter: x sweeps 0..W-1 inside y 0..H-1.
module raster_counter #(
  parameter int W = 640,
  parameter int H = 480,
  localparam int XW = (W > 1) ? $clog2(W) : 1,
  localparam int YW = (H > 1) ? $clog2(H) : 1
) (
  input  logic          draw_clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_ff @(posedge draw_clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (x_q == XW'(W - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(H - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == XW'(W - 1)) && (y_q == YW'(H - 1));

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame owner of the framebuffer write port: clear, snake stream, food cell,
// then a move tick every TICK_FRAMES completed frames.
module frame_sequencer
  import draw_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int TICK_FRAMES = 8
) (
  input  logic       draw_clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [9:0] snake_rx,
  input  logic [8:0] snake_ry,
  input  logic       snake_done,
  input  logic [9:0] food_x,
  input  logic [8:0] food_y,
  output logic       snake_cleared,
  output logic       move_tick,
  output logic       fb_we,
  output logic [9:0] fb_x,
  output logic [8:0] fb_y,
  output logic [1:0] fb_color,
  output logic       busy,
  output logic       overrun
);

  localparam int CXW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int CYW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam int FW  = $clog2(CELL);
  localparam int FCW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

  draw_state_e    state_q, state_d;
  logic           pending_q, pending_d;
  logic           overrun_q, overrun_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           fb_we_q, fb_we_d;
  logic [9:0]     fb_x_q, fb_x_d;
  logic [8:0]     fb_y_q, fb_y_d;
  logic [1:0]     fb_color_q, fb_color_d;

  logic [CXW-1:0] clr_x;
  logic [CYW-1:0] clr_y;
  logic           clr_last;
  logic [FW-1:0]  food_dx;
  logic [FW-1:0]  food_dy;
  logic           food_last;
  logic [10:0]    food_sum_x;
  logic [9:0]     food_sum_y;
  logic           food_in_range;
  logic           snake_in_range;

  raster_counter #(.W(SCREEN_W), .H(SCREEN_H)) u_clear_sweep (
    .draw_clk (draw_clk),
    .reset    (reset),
    .start    (state_q == IDLE),
    .step     (state_q == CLEAR),
    .x        (clr_x),
    .y        (clr_y),
    .last     (clr_last)
  );

  raster_counter #(.W(CELL), .H(CELL)) u_food_sweep (
    .draw_clk (draw_clk),
    .reset    (reset),
    .start    (state_q != FOOD),
    .step     (state_q == FOOD),
    .x        (food_dx),
    .y        (food_dy),
    .last     (food_last)
  );

  // Widened sums so a food cell near the right/bottom edge clips instead of wrapping.
  assign food_sum_x     = 11'(food_x) + 11'(food_dx);
  assign food_sum_y     = 10'(food_y) + 10'(food_dy);
  assign food_in_range  = (food_sum_x < 11'(SCREEN_W)) && (food_sum_y < 10'(SCREEN_H));
  assign snake_in_range = (11'(snake_rx) < 11'(SCREEN_W)) && (10'(snake_ry) < 10'(SCREEN_H));

  always_ff @(posedge draw_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      fb_we_q     <= 1'b0;
      fb_x_q      <= '0;
      fb_y_q      <= '0;
      fb_color_q  <= COLOR_BG;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      fb_we_q     <= fb_we_d;
      fb_x_q      <= fb_x_d;
      fb_y_q      <= fb_y_d;
      fb_color_q  <= fb_color_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    frame_cnt_d   = frame_cnt_q;
    fb_we_d       = 1'b0;
    fb_x_d        = '0;
    fb_y_d        = '0;
    fb_color_d    = COLOR_BG;
    snake_cleared = 1'b0;
    move_tick     = 1'b0;

    // One frame may queue behind the current one; further pulses are lost.
    if (frame_start && (state_q != IDLE)) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_start || pending_q) begin
          state_d   = CLEAR;
          pending_d = 1'b0;
        end
      end
      CLEAR: begin
        fb_we_d = 1'b1;
        fb_x_d  = 10'(clr_x);
        fb_y_d  = 9'(clr_y);
        if (clr_last) state_d = SNAKE_START;
      end
      SNAKE_START: begin
        snake_cleared = 1'b1;
        state_d       = SNAKE_PRIME;
      end
      SNAKE_PRIME: begin
        state_d = SNAKE_DRAW;
      end
      SNAKE_DRAW: begin
        if (snake_done) begin
          state_d = FOOD;
        end else begin
          fb_we_d    = snake_in_range;
          fb_x_d     = snake_rx;
          fb_y_d     = snake_ry;
          fb_color_d = COLOR_SNAKE;
        end
      end
      FOOD: begin
        fb_we_d    = food_in_range;
        fb_x_d     = food_sum_x[9:0];
        fb_y_d     = food_sum_y[8:0];
        fb_color_d = COLOR_FOOD;
        if (food_last) state_d = FINISH;
      end
      FINISH: begin
        if (frame_cnt_q == FCW'(TICK_FRAMES - 1)) begin
          move_tick   = 1'b1;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + FCW'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fb_we    = fb_we_q;
  assign fb_x     = fb_x_q;
  assign fb_y     = fb_y_q;
  assign fb_color = fb_color_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;

endmodule
